// File: rtl/mem_pkg.sv
// Shared types for the M-stage memory access unit: FSM states, access size codes
// and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // The reserved size code behaves as a word access.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and store replication on the way out,
// lane extraction and sign/zero extension of read data on the way back.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        // NOTE: every output is given a default before the case so no path infers a latch.
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{ext_i & half_lane[15]}}, half_lane};
            end
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{ext_i & byte_lane[7]}}, byte_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: turns one access into a single-beat req/ack bus
// transaction, stalling the pipeline until it completes or times out.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  MemSize_M,
    input  logic        BHExt_M,
    input  logic [31:0] Addr_M,
    input  logic [31:0] WData_M,
    output logic        stall_M,
    output logic [31:0] LoadData_M,
    output logic        load_valid_M,
    output logic        AdE_M,
    output logic        BusErr_M,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q, wdata_q, load_data_q;
    size_e            size_q;
    logic             we_q, ext_q, load_valid_q, bus_err_q;

    size_e       size_m;
    logic        access, misaligned, start, in_req;
    logic [3:0]  be_w;
    logic [31:0] wdata_w, rdata_w;

    assign size_m     = size_e'(MemSize_M);
    assign access     = MemRead_M | MemWrite_M;
    assign misaligned = is_misaligned(size_m, Addr_M[1:0]);
    assign start      = (state_q == IDLE) && access && !misaligned;
    assign in_req     = (state_q == REQ);

    mem_lane_align u_align (
        .size_i   (size_q),
        .addr_lo_i(addr_q[1:0]),
        .ext_i    (ext_q),
        .wdata_i  (wdata_q),
        .rdata_i  (bus_rdata),
        .be_o     (be_w),
        .wdata_o  (wdata_w),
        .rdata_o  (rdata_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the captured access fields are reset too, so the bus outputs and
            // LoadData_M are defined from the first cycle after reset.
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_WORD;
            we_q         <= 1'b0;
            ext_q        <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading last-cycle values.
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= Addr_M;
                        wdata_q <= WData_M;
                        size_q  <= size_m;
                        we_q    <= MemWrite_M;
                        ext_q   <= BHExt_M;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_ack) begin
                        if (!we_q) begin
                            load_data_q  <= rdata_w;
                            load_valid_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Timeout: a load still retires, but with zero data and a bus error.
                        if (!we_q) begin
                            load_data_q  <= '0;
                            load_valid_q <= 1'b1;
                        end
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_M      = start | in_req;
    assign AdE_M        = (state_q == IDLE) && access && misaligned;
    assign load_valid_M = load_valid_q;
    assign BusErr_M     = bus_err_q;
    assign LoadData_M   = load_data_q;

    assign bus_req   = in_req;
    assign bus_we    = in_req & we_q;
    assign bus_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be    = in_req ? be_w : 4'b0000;
    assign bus_wdata = in_req ? wdata_w : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by random
// accesses, each checked against a byte-lane reference model.
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_M, MemWrite_M, BHExt_M;
    logic [1:0]  MemSize_M;
    logic [31:0] Addr_M, WData_M;
    logic        stall_M, load_valid_M, AdE_M, BusErr_M;
    logic [31:0] LoadData_M;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_load;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .MemSize_M   (MemSize_M),
        .BHExt_M     (BHExt_M),
        .Addr_M      (Addr_M),
        .WData_M     (WData_M),
        .stall_M     (stall_M),
        .LoadData_M  (LoadData_M),
        .load_valid_M(load_valid_M),
        .AdE_M       (AdE_M),
        .BusErr_M    (BusErr_M),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'd1:    return 2;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int n, input int off);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + n);
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input int n, input int off, input logic ext,
                                               input logic [31:0] rdat);
        logic [31:0] v;
        v = rdat >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (ext && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (ext && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        MemSize_M  = 2'd0;
        BHExt_M    = 1'b0;
        Addr_M     = 32'h0;
        WData_M    = 32'h0;
    endtask

    // Entered just after a rising edge with the unit idle; leaves it the same way.
    // wait_n: REQ cycle index (from 0) on which ack is driven; <0 means never.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic ext, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int wait_n);
        int   n, off, k, exp_req;
        logic is_load, access, mis, timeout;
        n       = nbytes(sz);
        off     = int'(addr[1:0]);
        is_load = rd & ~wr;
        access  = rd | wr;
        mis     = access && ((off % n) != 0);
        timeout = (wait_n < 0) || (wait_n >= T);
        exp_req = timeout ? T : wait_n + 1;

        MemRead_M = rd; MemWrite_M = wr; MemSize_M = sz; BHExt_M = ext;
        Addr_M = addr; WData_M = wd;
        @(negedge clk);
        check({name, ":ade"}, AdE_M, mis);
        check({name, ":stall_idle"}, stall_M, access && !mis);
        check({name, ":req_idle"}, bus_req, 1'b0);

        if (!access || mis) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check({name, ":req_after"}, bus_req, 1'b0);
            check({name, ":stall_after"}, stall_M, 1'b0);
            check({name, ":ld_hold"}, LoadData_M, last_load);
            @(posedge clk); #1;
            return;
        end

        @(posedge clk); #1;
        MemRead_M = 1'($urandom); MemWrite_M = 1'($urandom); MemSize_M = 2'($urandom);
        BHExt_M = 1'($urandom); Addr_M = $urandom; WData_M = $urandom;

        k = 0;
        @(negedge clk);
        while (bus_req === 1'b1 && k < T + 4) begin
            check({name, ":stall_req"}, stall_M, 1'b1);
            check({name, ":ade_req"}, AdE_M, 1'b0);
            check({name, ":we"}, bus_we, wr);
            check({name, ":addr"}, bus_addr, {addr[31:2], 2'b00});
            check({name, ":be"}, bus_be, model_be(n, off));
            if (wr) check({name, ":wdata"}, bus_wdata, model_wdata(n, wd));
            bus_ack   = (k == wait_n);
            bus_rdata = (k == wait_n) ? rdat : $urandom;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            k++;
            @(negedge clk);
        end

        check({name, ":req_cycles"}, k, exp_req);
        check({name, ":stall_done"}, stall_M, 1'b0);
        check({name, ":buserr"}, BusErr_M, timeout);
        if (!timeout) check({name, ":lvalid"}, load_valid_M, is_load);
        if (is_load) begin
            last_load = timeout ? 32'h0 : model_load(n, off, ext, rdat);
            check({name, ":ldata"}, LoadData_M, last_load);
        end

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check({name, ":lvalid_pulse"}, load_valid_M, 1'b0);
        check({name, ":buserr_pulse"}, BusErr_M, 1'b0);
        check({name, ":stall_next"}, stall_M, 1'b0);
        if (is_load) check({name, ":ld_hold"}, LoadData_M, last_load);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r, w;
        logic        rd, wr;
        logic [31:0] addr;

        reset = 1'b1;
        idle_inputs();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        last_load = 32'h0;
        #12;
        check("rst:stall", stall_M, 1'b0);
        check("rst:req", bus_req, 1'b0);
        check("rst:lvalid", load_valid_M, 1'b0);
        check("rst:buserr", BusErr_M, 1'b0);
        check("rst:ldata", LoadData_M, 32'h0);
        check("rst:be", bus_be, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("w_st",   1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 2);
        run_op("sb_ld",  1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0);
        run_op("ub_ld",  1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0);
        run_op("h_st",   1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1);
        run_op("w_mis",  1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_4006, 32'h0, 32'h0, 0);
        run_op("to_ld",  1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_5678, -1);
        run_op("edge_ld",1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_5002, 32'h0, 32'h8001_7FFF, T - 1);
        run_op("both",   1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_6008, 32'hCAFE_F00D, 32'h0, 0);

        // Reset while a load is waiting for its ack.
        MemRead_M = 1'b1; MemSize_M = 2'd0; Addr_M = 32'h0000_7000;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mid_rst:req_before", bus_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst:req", bus_req, 1'b0);
        check("mid_rst:stall", stall_M, 1'b0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_load = 32'h0;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("mid_rst:lvalid", load_valid_M, 1'b0);
        check("mid_rst:ldata", LoadData_M, 32'h0);
        @(posedge clk); #1;
        run_op("post_rst_st", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_8001, 32'h0000_00A5, 32'h0, 0);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 7));
            rd = (r == 1) || (r >= 2 && r <= 4);
            wr = (r == 1) || (r >= 5);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            w = int'($urandom_range(0, 6)) - 1;
            run_op("rand", rd, wr, 2'($urandom), 1'($urandom), addr, $urandom, $urandom, w);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
